// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and data ports.
// One transaction at a time through IDLE/ACCESS/RESP, with a watchdog that aborts lost acks.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       owner_q;  // 1 = data port owns the current transaction
  logic       last_q;   // 1 = data port was served last
  logic       we_q;
  logic       err_q;
  logic [7:0] wd_q;
  logic       any_req;
  logic       grant_d;

  assign any_req = if_req | d_req;

  // Ties go to the port not served last; otherwise the lone requester wins.
  always_comb begin
    grant_d = d_req;
    if (if_req && d_req) begin
      grant_d = ~last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: if (mem_ack || (wd_q == WdLast)) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= 8'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q  <= grant_d;
            last_q   <= grant_d;
            we_q     <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : if_addr;
            wd_q     <= 8'd0;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
          end
        end
        StAccess: begin
          wd_q <= wd_q + 8'd1;
          // An ack on the watchdog's last cycle still counts as success.
          if (mem_ack) begin
            err_q <= 1'b0;
            if (!we_q) begin
              if (owner_q) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
          end else if (wd_q == WdLast) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req = (state_q == StAccess);
    mem_we  = (state_q == StAccess) & we_q;
    busy    = (state_q != StIdle);
    if_done = (state_q == StResp) & ~owner_q;
    d_done  = (state_q == StResp) & owner_q;
    err     = (state_q == StResp) & err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT = 4; memory ack/data driven by hand per step.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .err      (err),
    .busy     (busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_done", 64'({if_done, d_done, err}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    rst = 1'b0;

    // Single fetch, zero-wait
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    tick();
    chk("f1_mem_req", 64'(mem_req), 64'd1);
    chk("f1_mem_we", 64'(mem_we), 64'd0);
    chk("f1_mem_addr", 64'(mem_addr), 64'h40);
    chk("f1_busy", 64'(busy), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h2010_0005;
    tick();
    chk("f1_if_done", 64'(if_done), 64'd1);
    chk("f1_d_done", 64'(d_done), 64'd0);
    chk("f1_err", 64'(err), 64'd0);
    chk("f1_if_rdata", 64'(if_rdata), 64'h2010_0005);
    chk("f1_mem_req_off", 64'(mem_req), 64'd0);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    chk("f1_done_pulse", 64'(if_done), 64'd0);
    chk("f1_idle", 64'(busy), 64'd0);

    // Data write, 2 wait cycles
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_mem_we", 64'(mem_we), 64'd1);
    chk("wr_mem_addr", 64'(mem_addr), 64'h100);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    tick();
    chk("wr_wait_done", 64'(d_done), 64'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    chk("wr_d_done", 64'(d_done), 64'd1);
    chk("wr_err", 64'(err), 64'd0);
    chk("wr_d_rdata_kept", 64'(d_rdata), 64'd0);
    chk("wr_mem_we_off", 64'(mem_we), 64'd0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();
    chk("wr_done_pulse", 64'(d_done), 64'd0);

    // Data read of the same address, 2 wait cycles
    d_req = 1'b1;
    d_we  = 1'b0;
    tick();
    chk("rd_mem_we", 64'(mem_we), 64'd0);
    chk("rd_mem_req", 64'(mem_req), 64'd1);
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_d_done", 64'(d_done), 64'd1);
    chk("rd_d_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
    chk("rd_if_rdata_kept", 64'(if_rdata), 64'h2010_0005);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    // Both ports held: last served was data, so fetch, data, fetch, data
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h300;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d     = (i % 2 == 1);
      mem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      chk("rr_mem_addr", 64'(mem_addr), exp_d ? 64'h300 : 64'h200);
      tick();
      chk("rr_if_done", 64'(if_done), 64'(!exp_d));
      chk("rr_d_done", 64'(d_done), 64'(exp_d));
      tick();
      chk("rr_no_done", 64'({if_done, d_done}), 64'd0);
    end
    chk("rr_if_rdata", 64'(if_rdata), 64'hA000_0002);
    chk("rr_d_rdata", 64'(d_rdata), 64'hA000_0003);
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    // Timeout: no ack ever
    d_req  = 1'b1;
    d_addr = 32'h400;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("to_mem_req", 64'(mem_req), 64'd1);
      chk("to_no_done", 64'(d_done), 64'd0);
      tick();
    end
    chk("to_d_done", 64'(d_done), 64'd1);
    chk("to_err", 64'(err), 64'd1);
    chk("to_mem_req_off", 64'(mem_req), 64'd0);
    chk("to_d_rdata_kept", 64'(d_rdata), 64'hA000_0003);
    d_req = 1'b0;
    tick();
    chk("to_err_clear", 64'(err), 64'd0);

    // Ack on the 4th ACCESS cycle wins over timeout
    d_req  = 1'b1;
    d_addr = 32'h500;
    tick();
    tick();
    tick();
    tick();
    chk("ackto_mem_req", 64'(mem_req), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("ackto_d_done", 64'(d_done), 64'd1);
    chk("ackto_err", 64'(err), 64'd0);
    chk("ackto_d_rdata", 64'(d_rdata), 64'hCAFE_F00D);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    // Reset mid-access: async drop, no done, fetch wins the first tie afterwards
    d_req  = 1'b1;
    d_addr = 32'h600;
    tick();
    chk("mr_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_mem_req", 64'(mem_req), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    tick();
    chk("mr_no_done", 64'({if_done, d_done}), 64'd0);
    if_req  = 1'b1;
    if_addr = 32'h700;
    rst     = 1'b0;
    tick();
    chk("mr_grant_addr", 64'(mem_addr), 64'h700);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    chk("mr_if_done", 64'(if_done), 64'd1);
    chk("mr_d_done", 64'(d_done), 64'd0);
    chk("mr_if_rdata", 64'(if_rdata), 64'h5555_AAAA);
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port unified memory between the multi-cycle CPU's instruction-fetch stage (IF) and data-access stage (MEM). Each requester uses a req/done handshake and the arbiter sequences one memory transaction at a time through an IDLE/ACCESS/RESP state machine. When both ports are pending, the arbiter grants round-robin. A watchdog aborts any access whose memory acknowledge never arrives.

## Interface
- ADDR_W, 32, address width (matches CPU address length)
- DATA_W, 32, data width (matches CPU data length)
- TIMEOUT, 16, max ACCESS cycles without mem_ack before abort; legal range 2..255

- clk  in  1  system clock; rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held high with stable if_addr until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched word; held until next fetch completes
- d_req  in  1  data request; held high with stable d_addr/d_we/d_wdata until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data; held until next data read completes
- err  out  1  valid with a done pulse: access timed out and was aborted
- busy  out  1  state is not IDLE
- mem_req  out  1  memory access request (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_ack  in  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On an edge with any req high, select the owner and latch addr/we/wdata into the mem_* registers.
  - Set mem_req = 1 and go to ACCESS.
  - The fetch port always drives mem_we = 0.
- Arbitration:
  - One pending request: that port wins.
  - Both pending: grant the port not served last.
  - The last-served pointer updates at each grant and resets to "data", so fetch wins the first tie.
- ACCESS:
  - mem_req stays high and the mem_* registers stay stable.
  - The watchdog counter increments each cycle.
  - Edge with mem_ack = 1: capture mem_rdata into the owner's rdata register (reads only; writes leave it unchanged), clear mem_req and mem_we, go to RESP with err = 0.
  - Edge where the counter reaches TIMEOUT−1 with mem_ack = 0: clear mem_req and mem_we, leave rdata unchanged, go to RESP with err = 1.
  - A mem_ack arriving in the same cycle as the timeout takes precedence: the access succeeds.
- RESP:
  - The owner's done is high for exactly one cycle; err is high in that cycle if the access timed out.
  - The other port's done stays low.
  - Requests are ignored in RESP. Next state is IDLE.
- Requester rule: deassert req in the cycle after done. If req is still high in IDLE, it is treated as a new request.
- A req that drops before its done is a protocol violation and has undefined results. The arbiter still completes the latched transaction.
- mem_ack seen outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; if_done, d_done, err, busy, mem_req, mem_we = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; watchdog = 0; last-served = data.
- Reset asserted mid-transaction:
  - The arbiter immediately returns to IDLE and mem_req drops asynchronously.
  - No done pulse is produced for the aborted access.
- Zero-wait memory (mem_ack in the first ACCESS cycle):
  - Cycle 0: IDLE samples req.
  - Cycle 1: ACCESS with mem_req high.
  - Cycle 2: RESP with done high.
  - Cycle 3: IDLE.
  - Throughput: one transaction per 3 cycles when a req is already high in IDLE.
- With N wait cycles, latency from req sample to done is N+2 cycles.
- Timeout: done/err assert TIMEOUT+1 cycles after the req sample edge.
- busy = (state != IDLE), registered.

## Test plan
- Single fetch, zero-wait: if_req = 1, if_addr = 0x0000_0040, memory returns 0x2010_0005 with ack in the first ACCESS cycle -> mem_req high in cycle 1 with mem_we = 0; if_done pulses in cycle 2 with if_rdata = 0x2010_0005; d_done stays 0.
- Data write then read, 2 wait cycles: d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, then a read of 0x100 -> mem_we = 1 only during the write's ACCESS; each d_done arrives 4 cycles after its sample; d_rdata = 0xDEAD_BEEF after the read.
- Simultaneous requests: if_req and d_req both held continuously -> grant order is fetch, data, fetch, data; each done pulses once per grant.
- Timeout: TIMEOUT = 4, d_req read, mem_ack never asserted -> mem_req high for 4 cycles; d_done and err high together in the next cycle; d_rdata unchanged.
- Ack on the timeout cycle: mem_ack arrives in the 4th ACCESS cycle with TIMEOUT = 4 -> done with err = 0 and data captured.
- Reset mid-access: assert rst during ACCESS -> mem_req = 0 and busy = 0 immediately; no done pulse; after release, a new fetch request is granted first.
